mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
// - Shares the single RAM port between the instruction and data caches of both cores.
// - Requesters: 0=core0 I, 1=core0 D, 2=core1 I, 3=core1 D.
// - Round-robin, non-preemptive: a grant is held until RAM completes the access.
// - Sits between the cache pair of each core and the RAM. Pipeline stalls come from req_wait.
// PARAMETERS
// - NREQ  4   number of requesters; must be even, odd indices are data caches
// - AW    32  address width
// - DW    32  data width
// PORTS
// - CLK        in   1        clock, all state on rising edge
// - RST        in   1        synchronous active-high reset
// - req_ren    in   NREQ     per-requester read request
// - req_wen    in   NREQ     per-requester write request
// - req_addr   in   NREQ*AW  packed addresses, requester i at [i*AW +: AW]
// - req_store  in   NREQ*DW  packed write data, requester i at [i*DW +: DW]
// - req_wait   out  NREQ     1 = requester must hold its request and stall
// - req_load   out  DW       RAM read data, broadcast to all requesters
// - ram_ren    out  1        RAM read enable
// - ram_wen    out  1        RAM write enable
// - ram_addr   out  AW       RAM address
// - ram_store  out  DW       RAM write data
// - ram_load   in   DW       RAM read data
// - ram_ready  in   1        RAM access completes this cycle
// BEHAVIOUR
// - Reset:
//   - state=IDLE, gnt=0, ptr=0
//   - ram_ren=ram_wen=0, ram_addr=ram_store=0
//   - req_wait = (req_ren|req_wen), i.e. every active requester waits
// - Active requester: req_act[i] = req_ren[i] | req_wen[i].
// - FSM: IDLE, BUSY.
//   - IDLE: pick the first i with req_act[i], searching ptr, ptr+1, ... mod NREQ.
//     If found: gnt<=i, state<=BUSY (registered, 1-cycle arbitration latency).
//     If none: stay IDLE.
//   - BUSY: ram_* is driven from requester gnt.
//     - If req_wen[gnt]=1: ram_wen=1, ram_ren=0 (write wins when both are set).
//     - Otherwise: ram_ren=req_ren[gnt].
//     - ram_ready=1: access done. state<=IDLE, ptr<=(gnt+1) mod NREQ.
//   - BUSY with req_act[gnt]=0 (requester withdrew): abort.
//     - ram_ren=ram_wen=0 that same cycle.
//     - state<=IDLE, ptr<=(gnt+1) mod NREQ.
//   - BUSY, ram_ready=0: hold gnt. New requests do not preempt.
// - Outputs:
//   - ram_* are combinational from gnt while in BUSY. In IDLE they are 0.
//   - req_wait[i] = req_act[i] & ~(state==BUSY & gnt==i & ram_ready).
//   - req_load = ram_load, always.
// - Timing:
//   - A requester sees req_wait drop in exactly the cycle ram_ready is high for its grant.
//   - Minimum access is 2 cycles: IDLE arbitration, then BUSY with ram_ready.
//   - IDLE always lasts at least 1 cycle between grants (turnaround).
// - Boundary cases:
//   - ptr wraps from NREQ-1 to 0.
//   - A requester re-asserting right after completion goes to the back of the rotation.
//   - ram_ready while IDLE is ignored.
//   - RST during BUSY: next cycle is IDLE, ram_* return to 0 immediately, and the access is dropped.
// CONFIGURATION
// - MEMARB_DPRIO_EN defined:
//   - In IDLE, if any odd (data) requester is active, search only data requesters from ptr.
//   - Instruction requesters are granted only when no data request is pending.
//   - ptr update is unchanged.
// - MEMARB_DPRIO_EN undefined: plain round-robin over all NREQ requesters.
// TESTING
// - Reset, then req_ren=4'b0001, addr0=0x40, RAM ready after 3 cycles:
//   -> ram_ren=1, ram_addr=0x40 from cycle 1; req_wait[0] falls on ready; ptr=1.
// - req_ren=4'b1111 held, ram_ready=1 every BUSY cycle:
//   -> grant order 0,1,2,3,0; each grant separated by one IDLE cycle.
// - req_wen[1]=req_ren[1]=1, store=0xDEADBEEF:
//   -> ram_wen=1, ram_ren=0, ram_store=0xDEADBEEF.
// - gnt=2 in BUSY, req_ren[2] dropped before ready:
//   -> ram_ren=0 that cycle; IDLE next; ptr=3.
// - RST pulsed during BUSY:
//   -> state=IDLE, ram_*=0 next cycle; first grant after reset goes to lowest active index.
// - MEMARB_DPRIO_EN, ptr=0, req_ren=4'b0101 and req_ren[3]=1:
//   -> gnt=3 first; 0 and 2 are granted only after requester 3 drops.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin, non-preemptive arbiter sharing one RAM port between the I/D caches of two cores.
// Optional build macro MEMARB_DPRIO_EN: data (odd) requesters take precedence over instruction ones.
module mem_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 32,
  parameter int DW   = 32
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NREQ-1:0]    req_ren,
  input  logic [NREQ-1:0]    req_wen,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_store,
  output logic [NREQ-1:0]    req_wait,
  output logic [DW-1:0]      req_load,
  output logic               ram_ren,
  output logic               ram_wen,
  output logic [AW-1:0]      ram_addr,
  output logic [DW-1:0]      ram_store,
  input  logic [DW-1:0]      ram_load,
  input  logic               ram_ready
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [GW-1:0]   gnt, gnt_nxt, ptr, ptr_nxt;
  logic [GW-1:0]   pick, sel;
  logic [NREQ-1:0] req_act, cand;
  logic            found, busy;

  assign req_act  = req_ren | req_wen;
  assign req_load = ram_load;
  // Reset blanks the RAM port in the same cycle so an in-flight access is dropped cleanly.
  assign busy     = (state == BUSY) && !RST;

`ifdef MEMARB_DPRIO_EN
  logic [NREQ-1:0] data_act;

  always_comb begin
    data_act = '0;
    for (int i = 1; i < NREQ; i += 2) data_act[i] = req_act[i];
    cand = (|data_act) ? data_act : req_act;
  end
`else
  assign cand = req_act;
`endif

  // First candidate at or after ptr, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    sel   = '0;
    for (int k = 0; k < NREQ; k++) begin
      sel = GW'((int'(ptr) + k) % NREQ);
      if (!found && cand[sel]) begin
        found = 1'b1;
        pick  = sel;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    ptr_nxt   = ptr;
    ram_ren   = 1'b0;
    ram_wen   = 1'b0;
    ram_addr  = '0;
    ram_store = '0;
    case (state)
      IDLE: begin
        if (found) begin
          gnt_nxt   = pick;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (busy) begin
          ram_addr  = req_addr[int'(gnt)*AW +: AW];
          ram_store = req_store[int'(gnt)*DW +: DW];
          ram_wen   = req_wen[gnt];
          ram_ren   = req_ren[gnt] & ~req_wen[gnt];
        end
        // Completion or withdrawal both release the port and advance the rotation.
        if (ram_ready || !req_act[gnt]) begin
          state_nxt = IDLE;
          ptr_nxt   = (gnt == GW'(NREQ - 1)) ? '0 : gnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_wait = '0;
    for (int i = 0; i < NREQ; i++)
      req_wait[i] = req_act[i] && !(busy && (gnt == GW'(i)) && ram_ready);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      gnt   <= '0;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      ptr   <= ptr_nxt;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, single access, rotation, write priority, abort, reset-in-BUSY, data priority.
module tb_mem_arbiter;
  localparam int NREQ = 4;
  localparam int AW   = 32;
  localparam int DW   = 32;

  logic               CLK;
  logic               RST;
  logic [NREQ-1:0]    req_ren, req_wen, req_wait;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_store;
  logic [DW-1:0]      req_load, ram_store, ram_load;
  logic [AW-1:0]      ram_addr;
  logic               ram_ren, ram_wen, ram_ready;

  int errors = 0;
  int checks = 0;

  mem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .CLK(CLK), .RST(RST),
    .req_ren(req_ren), .req_wen(req_wen), .req_addr(req_addr), .req_store(req_store),
    .req_wait(req_wait), .req_load(req_load),
    .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_store(ram_store),
    .ram_load(ram_load), .ram_ready(ram_ready)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [AW-1:0] addr_of(input int i);
    return 32'h1000 + 32'(i) * 32'h100;
  endfunction

  task automatic default_addrs();
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i*AW +: AW]  = addr_of(i);
      req_store[i*DW +: DW] = 32'hA000_0000 + 32'(i);
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  initial begin
    int g;
    logic [NREQ-1:0] wexp;
    int gexp[8];

    RST = 1'b1; req_ren = 4'b0001; req_wen = '0; ram_ready = 1'b0; ram_load = 32'h5A5A_1234;
    default_addrs();
    req_addr[0 +: AW] = 32'h40;
    tick(); tick();
    // Reset state
    check("rst_wait", req_wait, 4'b0001);
    check("rst_ren", ram_ren, 1'b0);
    check("rst_wen", ram_wen, 1'b0);
    check("rst_addr", ram_addr, 32'h0);
    check("rst_ptr", dut.ptr, 2'd0);
    check("load_bcast", req_load, 32'h5A5A_1234);

    // Single read, ready on third BUSY cycle
    RST = 1'b0; settle();
    check("t1_idle_ren", ram_ren, 1'b0);
    check("t1_idle_wait", req_wait, 4'b0001);
    tick();
    check("t1_c1_ren", ram_ren, 1'b1);
    check("t1_c1_addr", ram_addr, 32'h40);
    check("t1_c1_wait", req_wait, 4'b0001);
    tick();
    check("t1_c2_wait", req_wait, 4'b0001);
    tick();
    ram_ready = 1'b1; settle();
    check("t1_c3_wait", req_wait, 4'b0000);
    check("t1_c3_ren", ram_ren, 1'b1);
    tick();
    ram_ready = 1'b0; req_ren = '0; settle();
    check("t1_ptr", dut.ptr, 2'd1);
    check("t1_after_ren", ram_ren, 1'b0);

    // Full rotation with ready always high (ready in IDLE must be ignored)
    default_addrs();
    do_reset();
    req_ren = 4'b1111; ram_ready = 1'b1; settle();
    check("rr_k0_ren", ram_ren, 1'b0);
    for (int k = 1; k < 10; k++) begin
      tick();
      if (k % 2 == 0) begin
        check($sformatf("rr_k%0d_idle_ren", k), ram_ren, 1'b0);
        check($sformatf("rr_k%0d_idle_wait", k), req_wait, 4'b1111);
      end else begin
        g = ((k - 1) / 2) % NREQ;
        wexp = 4'b1111 & ~(4'b0001 << g);
        check($sformatf("rr_k%0d_ren", k), ram_ren, 1'b1);
        check($sformatf("rr_k%0d_addr", k), ram_addr, addr_of(g));
        check($sformatf("rr_k%0d_wait", k), req_wait, wexp);
      end
    end
    req_ren = '0; ram_ready = 1'b0;
    tick();

    // Write wins over read
    do_reset();
    req_ren = 4'b0010; req_wen = 4'b0010; req_store[1*DW +: DW] = 32'hDEADBEEF;
    tick();
    check("wr_wen", ram_wen, 1'b1);
    check("wr_ren", ram_ren, 1'b0);
    check("wr_store", ram_store, 32'hDEADBEEF);
    check("wr_addr", ram_addr, addr_of(1));
    ram_ready = 1'b1; settle();
    check("wr_wait", req_wait, 4'b0000);
    tick();
    ram_ready = 1'b0; req_ren = 4'b0100; req_wen = '0; settle();

    // Requester 2 withdraws before ready
    tick();
    check("ab_ren", ram_ren, 1'b1);
    check("ab_addr", ram_addr, addr_of(2));
    req_ren = '0; settle();
    check("ab_drop_ren", ram_ren, 1'b0);
    check("ab_drop_wen", ram_wen, 1'b0);
    tick();
    check("ab_idle_ren", ram_ren, 1'b0);
    check("ab_ptr", dut.ptr, 2'd3);
    req_ren = 4'b0101; settle();
    tick();
    check("ab_next_addr", ram_addr, addr_of(0));

    // Reset while BUSY
    RST = 1'b1; req_ren = 4'b0110; settle();
    check("rb_ren_now", ram_ren, 1'b0);
    check("rb_addr_now", ram_addr, 32'h0);
    check("rb_wait_now", req_wait, 4'b0110);
    tick();
    RST = 1'b0; settle();
    check("rb_idle_ren", ram_ren, 1'b0);
    check("rb_ptr", dut.ptr, 2'd0);
    tick();
    check("rb_first_ren", ram_ren, 1'b1);
    check("rb_first_addr", ram_addr, addr_of(1));
    ram_ready = 1'b1;
    tick();
    ram_ready = 1'b0; req_ren = '0;
    tick();

    // Data priority (or plain round-robin when disabled)
`ifdef MEMARB_DPRIO_EN
    gexp = '{-1, 3, -1, 3, -1, 0, -1, 2};
`else
    gexp = '{-1, 0, -1, 2, -1, 0, -1, 2};
`endif
    do_reset();
    req_ren = 4'b1101; ram_ready = 1'b1; settle();
    for (int c = 1; c < 8; c++) begin
      tick();
      if (c == 4) begin
        req_ren = 4'b0101;
        settle();
      end
      if (gexp[c] < 0) begin
        check($sformatf("dp_c%0d_idle_ren", c), ram_ren, 1'b0);
      end else begin
        check($sformatf("dp_c%0d_ren", c), ram_ren, 1'b1);
        check($sformatf("dp_c%0d_addr", c), ram_addr, addr_of(gexp[c]));
      end
    end
    req_ren = '0; ram_ready = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
